// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package demux_pkg;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Largest supported output count.
  localparam int NOUT_MAX = 8;

  // A destination index is legal only when it names an existing output.
  function automatic logic sel_valid(input logic [31:0] sel, input int unsigned nout);
    return (sel < nout);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot: holds a beat until its consumer takes it.
// free_o tells the top whether a load this cycle can be absorbed.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // State and payload registers; payload only moves on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load always wins (reload when draining at the same time).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end
      end
      SLOT_FULL: begin
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end else if (ready_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;
  // Slot can take a beat if empty now or emptied by this cycle's handshake.
  assign free_o  = ~valid_o | ready_i;

endmodule

// File: rtl/demux_stream.sv
// 1-to-NOUT valid/ready stream demultiplexer with one registered slot per output.
// Optional broadcast (all-or-nothing write to every slot) under DEMUX_BCAST_EN.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NOUT  = 2,
  localparam int SELW = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_data_i,
  input  logic [SELW-1:0]       in_sel_i,
`ifdef DEMUX_BCAST_EN
  input  logic                  in_bcast_i,
`endif
  output logic [NOUT-1:0]       out_valid_o,
  input  logic [NOUT-1:0]       out_ready_i,
  output logic [NOUT*WIDTH-1:0] out_data_o,
  output logic                  sel_err_o
);

  logic [NOUT-1:0] free;
  logic [NOUT-1:0] load;
  logic            sel_ok;
  logic            free_sel;
  logic            bcast;
  logic            accept;
  logic            sel_err_q, sel_err_d;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast_i;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok = sel_valid(32'(in_sel_i), NOUT);

  // Pick the selected slot's free flag without indexing past NOUT.
  always_comb begin
    free_sel = 1'b0;
    for (int i = 0; i < NOUT; i++) begin
      if (32'(in_sel_i) == i) free_sel = free[i];
    end
  end

  // Ready depends only on the destination(s) of this beat, never on in_valid_i,
  // so a stall elsewhere cannot block it. Illegal selects are always swallowed.
  assign in_ready_o = bcast ? (&free) : (~sel_ok | free_sel);
  assign accept     = in_valid_i & in_ready_o;

  assign sel_err_d  = sel_err_q | (accept & ~bcast & ~sel_ok);

  // Sticky illegal-select flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err_o = sel_err_q;

  for (genvar g = 0; g < NOUT; g++) begin : g_slot
    assign load[g] = accept & (bcast | (sel_ok & (32'(in_sel_i) == g)));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[g]),
      .data_i  (in_data_i),
      .ready_i (out_ready_i[g]),
      .valid_o (out_valid_o[g]),
      .data_o  (out_data_o[g*WIDTH +: WIDTH]),
      .free_o  (free[g])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream (NOUT=3, so an illegal select exists).
// Build with +define+DEMUX_BCAST_EN to cover broadcast as well.
module tb_demux_stream;

  localparam int W = 32;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [1:0]     in_sel = '0;
`ifdef DEMUX_BCAST_EN
  logic           in_bcast = 1'b0;
`endif
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '1;
  logic [N*W-1:0] out_data;
  logic           sel_err;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  demux_stream #(.WIDTH(W), .NOUT(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast_i  (in_bcast),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .sel_err_o   (sel_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: what each output currently owes its consumer
  bit         m_full [N];
  bit [W-1:0] m_word [N];
  bit         m_err;

  function automatic bit m_bc();
`ifdef DEMUX_BCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  // Can output i take a beat now: nothing owed, or what is owed is being taken.
  function automatic bit m_room(int i);
    return !m_full[i] || out_ready[i];
  endfunction

  function automatic bit m_ready();
    bit r;
    if (m_bc()) begin
      r = 1'b1;
      for (int i = 0; i < N; i++) r = r & m_room(i);
    end else if (in_sel >= N) begin
      r = 1'b1;
    end else begin
      r = m_room(int'(in_sel));
    end
    return r;
  endfunction

  function automatic bit m_goes_to(int i);
    return m_bc() || (int'(in_sel) == i);
  endfunction

  function automatic logic [N-1:0] m_valid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] m_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = m_word[i];
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_full[i] <= 1'b0;
        m_word[i] <= '0;
      end
      m_err <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid && m_ready() && m_goes_to(i)) begin
          m_full[i] <= 1'b1;
          m_word[i] <= in_data;
        end else if (m_full[i] && out_ready[i]) begin
          m_full[i] <= 1'b0;
        end
      end
      if (in_valid && m_ready() && !m_bc() && in_sel >= N) m_err <= 1'b1;
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 4;
      if (in_ready !== m_ready()) begin
        fails++;
        $display("FAIL cyc_in_ready t=%0t got %b want %b", $time, in_ready, m_ready());
      end
      if (out_valid !== m_valid()) begin
        fails++;
        $display("FAIL cyc_out_valid t=%0t got %b want %b", $time, out_valid, m_valid());
      end
      if (out_data !== m_data()) begin
        fails++;
        $display("FAIL cyc_out_data t=%0t got %h want %h", $time, out_data, m_data());
      end
      if (sel_err !== m_err) begin
        fails++;
        $display("FAIL cyc_sel_err t=%0t got %b want %b", $time, sel_err, m_err);
      end
    end
  end

  // ---------------- directed helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Present one beat for one cycle; called and returns just after a rising edge.
  task automatic beat(input logic [W-1:0] d, input logic [1:0] s, output bit rdy);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit r;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 128'(out_valid), 128'(3'b000));
    chk("reset_data", 128'(out_data), 128'd0);
    chk("reset_err", 128'(sel_err), 128'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Unicast to two outputs, consumers ready
    out_ready = 3'b111;
    beat(32'hA5A5_0001, 2'd0, r);
    chk("uni0_ready", 128'(r), 128'd1);
    chk("uni0_valid", 128'(out_valid), 128'(3'b001));
    chk("uni0_data", 128'(out_data[0 +: W]), 128'(32'hA5A5_0001));
    beat(32'h5A5A_0002, 2'd1, r);
    chk("uni1_valid", 128'(out_valid), 128'(3'b010));
    chk("uni1_data", 128'(out_data[W +: W]), 128'(32'h5A5A_0002));
    idle(1);

    // Stall isolation: slot0 consumer stalled
    out_ready = 3'b110;
    beat(32'h0000_0100, 2'd0, r);
    chk("stall_first", 128'(r), 128'd1);
    beat(32'h0000_0101, 2'd0, r);
    chk("stall_second", 128'(r), 128'd0);
    beat(32'h0000_0102, 2'd0, r);
    chk("stall_third", 128'(r), 128'd0);
    beat(32'h0000_0200, 2'd1, r);
    chk("stall_other_ready", 128'(r), 128'd1);
    chk("stall_valid", 128'(out_valid), 128'(3'b011));
    chk("stall_hold", 128'(out_data[0 +: W]), 128'(32'h0000_0100));
    out_ready = 3'b111;
    idle(1);

    // Simultaneous drain and load of slot0
    out_ready = 3'b110;
    beat(32'h11, 2'd0, r);
    chk("dl_fill", 128'(out_data[0 +: W]), 128'(32'h11));
    out_ready = 3'b111;
    beat(32'h22, 2'd0, r);
    chk("dl_ready", 128'(r), 128'd1);
    chk("dl_valid", 128'(out_valid[0]), 128'd1);
    chk("dl_data", 128'(out_data[0 +: W]), 128'(32'h22));
    idle(1);

    // Illegal select
    beat(32'hDEAD_0003, 2'd3, r);
    chk("ill_ready", 128'(r), 128'd1);
    chk("ill_valid", 128'(out_valid), 128'(3'b000));
    chk("ill_err", 128'(sel_err), 128'd1);
    beat(32'h33, 2'd2, r);
    chk("ill_after_valid", 128'(out_valid), 128'(3'b100));
    chk("ill_sticky", 128'(sel_err), 128'd1);
    idle(1);

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every slot to have room, then lands everywhere at once
    out_ready = 3'b011;
    beat(32'h7, 2'd2, r);
    in_bcast = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBEEF;
    @(negedge clk);
    chk("bc_blocked", 128'(in_ready), 128'd0);
    @(posedge clk);
    #1;
    chk("bc_none", 128'(out_valid), 128'(3'b100));
    out_ready = 3'b111;
    @(negedge clk);
    chk("bc_open", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcast = 1'b0;
    chk("bc_valid", 128'(out_valid), 128'(3'b111));
    chk("bc_data", 128'(out_data), 128'({32'hBEEF, 32'hBEEF, 32'hBEEF}));
    idle(1);
`endif

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_sel    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      out_ready = 3'($urandom);
`ifdef DEMUX_BCAST_EN
      in_bcast  = ($urandom_range(0, 7) == 0);
`endif
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
`ifdef DEMUX_BCAST_EN
    in_bcast  = 1'b0;
`endif
    out_ready = 3'b111;
    idle(2);

    // Reset in the middle of traffic with slot0 holding a beat
    out_ready = 3'b000;
    beat(32'hCAFE, 2'd0, r);
    chk("mr_full", 128'(out_valid), 128'(3'b001));
    in_valid = 1'b1;
    in_data  = 32'hF00D;
    in_sel   = 2'd1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 128'(out_valid), 128'(3'b000));
    chk("mr_data", 128'(out_data), 128'd0);
    chk("mr_err", 128'(sel_err), 128'd0);
    idle(2);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    chk("mr_after", 128'(out_valid), 128'(3'b000));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
